hazard_scoreboard: RTL and testbench

//   Decode-stage RAW hazard detector for the 5-stage WISC pipeline.
//   - Consumes the decoded read count (0/1/2 source registers) and the source/destination fields of the instruction in ID.
//   - Tracks destination registers of instructions in flight.
//   - Raises stall while any used source register has a pending write.
//   - Each stall cycle injects a bubble (NOP) into EX; the ID instruction is held.

---
 rtl/wisc_pkg.sv | 25 ++
 rtl/sb_slot_cmp.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 93 +++++++++
 tb/tb_hazard_scoreboard.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions: register width, opcodes, read-count encodings.
package wisc_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_ALU_R = 5'b11011;

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_ONE  = 2'd1;
  localparam logic [1:0] RD_TWO  = 2'd2;

  // Any nonzero read count means rs is consumed.
  function automatic logic uses_rs(input logic [1:0] n);
    return n != RD_NONE;
  endfunction

  // Count 2 or 3 means rt is consumed as well.
  function automatic logic uses_rt(input logic [1:0] n);
    return n >= RD_TWO;
  endfunction

endpackage

// File: rtl/sb_slot_cmp.sv
// One in-flight scoreboard slot {v, rd} with its rs/rt comparators.
module sb_slot_cmp
  import wisc_pkg::*;
#(
  parameter int unsigned REG_W = wisc_pkg::REG_W,
  parameter bit          CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_v,
  input  logic [REG_W-1:0] i_rd,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_use_rs,
  input  logic             i_use_rt,
  output logic             o_v,
  output logic [REG_W-1:0] o_rd,
  output logic             o_hit
);

  logic             r_v;
  logic [REG_W-1:0] r_rd;
  logic             w_match;

  // Slot register: shifts in the younger entry every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= 1'b0;
      r_rd <= '0;
    end else begin
      r_v  <= i_v;
      r_rd <= i_rd;
    end
  end

  assign w_match = (i_use_rs && (r_rd == i_rs)) || (i_use_rt && (r_rd == i_rt));
  // Slots whose write is already visible to ID (bypassed WB) never report a hit.
  assign o_hit   = CHECK ? (r_v & w_match) : 1'b0;
  assign o_v     = r_v;
  assign o_rd    = r_rd;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector: tracks in-flight destinations, stalls ID on a pending write.
module hazard_scoreboard
  import wisc_pkg::*;
#(
  parameter int unsigned REG_W     = wisc_pkg::REG_W,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_regReads,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned N_CHK = DEPTH - WB_BYPASS;

  logic             w_use_rs;
  logic             w_use_rt;
  logic             w_stall;
  logic             w_ins_v;
  logic             w_v  [DEPTH];
  logic [REG_W-1:0] w_rd [DEPTH];
  logic [DEPTH-1:0] w_hit;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_use_rs = uses_rs(id_regReads);
  assign w_use_rt = uses_rt(id_regReads);

  // A squashed or empty ID slot never stalls; otherwise any checked hit stalls.
  assign w_stall  = id_valid & ~flush & (|w_hit);
  // Stalled or squashed cycles push a bubble into EX.
  assign w_ins_v  = id_valid & ~w_stall & ~flush & id_writes;

  // Slot chain: slot0=EX, slot1=MEM, ... ; the oldest entry falls off the end.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == 0) begin : g_head
      sb_slot_cmp #(
        .REG_W (REG_W),
        .CHECK (N_CHK > 0)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .i_v      (w_ins_v),
        .i_rd     (id_rd),
        .i_rs     (id_rs),
        .i_rt     (id_rt),
        .i_use_rs (w_use_rs),
        .i_use_rt (w_use_rt),
        .o_v      (w_v[i]),
        .o_rd     (w_rd[i]),
        .o_hit    (w_hit[i])
      );
    end else begin : g_tail
      sb_slot_cmp #(
        .REG_W (REG_W),
        .CHECK (i < N_CHK)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .i_v      (w_v[i-1]),
        .i_rd     (w_rd[i-1]),
        .i_rs     (id_rs),
        .i_rt     (id_rt),
        .i_use_rs (w_use_rs),
        .i_use_rt (w_use_rt),
        .o_v      (w_v[i]),
        .o_rd     (w_rd[i]),
        .o_hit    (w_hit[i])
      );
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed test of hazard_scoreboard: default, no-bypass and deep instances share stimulus.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_regReads;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_writes;
  logic [2:0]  id_rd;
  logic        flush;

  logic        stall, stall_nb, stall_sat;
  logic [15:0] cnt, cnt_nb, cnt_sat;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regReads(id_regReads),
    .id_rs(id_rs), .id_rt(id_rt), .id_writes(id_writes), .id_rd(id_rd),
    .flush(flush), .stall(stall), .stall_cnt(cnt)
  );

  hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regReads(id_regReads),
    .id_rs(id_rs), .id_rt(id_rt), .id_writes(id_writes), .id_rd(id_rd),
    .flush(flush), .stall(stall_nb), .stall_cnt(cnt_nb)
  );

  // Deep chain so a self-dependent stream stalls almost every cycle.
  hazard_scoreboard #(.DEPTH(32), .WB_BYPASS(0)) u_dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regReads(id_regReads),
    .id_rs(id_rs), .id_rt(id_rt), .id_writes(id_writes), .id_rd(id_rd),
    .flush(flush), .stall(stall_sat), .stall_cnt(cnt_sat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] reads, input logic [2:0] rs,
                       input logic [2:0] rt, input logic wr, input logic [2:0] rd,
                       input logic fl);
    id_valid    = v;
    id_regReads = reads;
    id_rs       = rs;
    id_rt       = rt;
    id_writes   = wr;
    id_rd       = rd;
    flush       = fl;
  endtask

  task automatic nop();
    drive(1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  // One cycle: settle, check stall, take the edge, resume 1ns after it.
  task automatic cyc(input string tag, input logic exp_stall);
    #2;
    chk(tag, {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    if (exp_stall) exp_cnt++;
  endtask

  task automatic drain(input int n);
    nop();
    for (int i = 0; i < n; i++) cyc("drain", 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    nop();
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);
    do_reset();

    // 1: independent stream
    drive(1'b1, 2'd2, 3'd4, 3'd5, 1'b1, 3'd1, 1'b0); cyc("t1_add_r1", 1'b0);
    drive(1'b1, 2'd2, 3'd6, 3'd7, 1'b1, 3'd2, 1'b0); cyc("t1_add_r2", 1'b0);
    drive(1'b1, 2'd2, 3'd4, 3'd6, 1'b1, 3'd3, 1'b0); cyc("t1_add_r3", 1'b0);
    chk("t1_cnt", {16'd0, cnt}, 32'd0);
    drain(4);

    // 2: producer directly ahead -> 2 stall cycles
    drive(1'b1, 2'd1, 3'd1, 3'd0, 1'b1, 3'd3, 1'b0); cyc("t2_addi", 1'b0);
    drive(1'b1, 2'd2, 3'd3, 3'd2, 1'b1, 3'd4, 1'b0);
    cyc("t2_stall_a", 1'b1);
    cyc("t2_stall_b", 1'b1);
    cyc("t2_go", 1'b0);
    chk("t2_cnt", {16'd0, cnt}, 32'd2);
    drain(4);

    // 3: producer two back -> 1 cycle (bypass) / 2 cycles (no bypass)
    drive(1'b1, 2'd1, 3'd1, 3'd0, 1'b1, 3'd3, 1'b0); cyc("t3_addi", 1'b0);
    nop(); cyc("t3_nop", 1'b0);
    drive(1'b1, 2'd2, 3'd1, 3'd3, 1'b0, 3'd0, 1'b0);
    #2; chk("t3_nb_a", {31'd0, stall_nb}, 32'd1);
    cyc("t3_st_a", 1'b1);
    #2; chk("t3_nb_b", {31'd0, stall_nb}, 32'd1);
    cyc("t3_st_b", 1'b0);
    #2; chk("t3_nb_c", {31'd0, stall_nb}, 32'd0);
    cyc("t3_st_c", 1'b0);
    chk("t3_cnt", {16'd0, cnt}, 32'd3);
    drain(4);

    // 4: rt ignored when regReads=1; used when 2 or 3; rs ignored when 0
    drive(1'b1, 2'd1, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0); cyc("t4_prod", 1'b0);
    drive(1'b1, 2'd1, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0); #2;
    chk("t4_rt_unused", {31'd0, stall}, 32'd0);
    drive(1'b1, 2'd0, 3'd5, 3'd5, 1'b0, 3'd0, 1'b0); #2;
    chk("t4_none", {31'd0, stall}, 32'd0);
    drive(1'b1, 2'd2, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0);
    cyc("t4_rt_used_a", 1'b1);
    cyc("t4_rt_used_b", 1'b1);
    cyc("t4_rt_go", 1'b0);
    drain(4);
    drive(1'b1, 2'd1, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0); cyc("t4_prod2", 1'b0);
    drive(1'b1, 2'd3, 3'd1, 3'd5, 1'b0, 3'd0, 1'b0);
    cyc("t4_reads3", 1'b1);
    drain(4);

    // Self-dependency and R0 as an ordinary register
    drive(1'b1, 2'd2, 3'd2, 3'd2, 1'b1, 3'd2, 1'b0); cyc("self_dep", 1'b0);
    drain(4);
    drive(1'b1, 2'd1, 3'd1, 3'd0, 1'b1, 3'd0, 1'b0); cyc("r0_prod", 1'b0);
    drive(1'b1, 2'd1, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc("r0_cons", 1'b1);
    drain(4);
    chk("cnt_mid", {16'd0, cnt}, exp_cnt);

    // 5: flush overrides stall and inserts nothing; invalid ID never stalls
    drive(1'b1, 2'd1, 3'd1, 3'd0, 1'b1, 3'd3, 1'b0); cyc("t5_prod", 1'b0);
    drive(1'b0, 2'd2, 3'd3, 3'd1, 1'b1, 3'd6, 1'b0); #2;
    chk("t5_invalid", {31'd0, stall}, 32'd0);
    drive(1'b1, 2'd2, 3'd3, 3'd1, 1'b1, 3'd6, 1'b1);
    cyc("t5_flush", 1'b0);
    drive(1'b1, 2'd1, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc("t5_not_inserted", 1'b0);
    drain(4);

    // 6: async reset mid-stall
    drive(1'b1, 2'd1, 3'd1, 3'd0, 1'b1, 3'd4, 1'b0); cyc("t6_prod", 1'b0);
    drive(1'b1, 2'd1, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0); #2;
    chk("t6_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_stall", {31'd0, stall}, 32'd0);
    chk("t6_async_cnt", {16'd0, cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    cyc("t6_after", 1'b0);
    chk("t6_cnt_after", {16'd0, cnt}, 32'd0);

    // Saturation: self-dependent stream through the deep instance
    do_reset();
    drive(1'b1, 2'd1, 3'd1, 3'd1, 1'b1, 3'd1, 1'b0);
    repeat (33) @(posedge clk);
    #1;
    chk("sat_first", {16'd0, cnt_sat}, 32'd32);
    repeat (68000 - 33) @(posedge clk);
    #1;
    chk("sat_full", {16'd0, cnt_sat}, 32'hFFFF);
    chk("sat_dflt", {16'd0, cnt}, 32'd45333);
    chk("sat_nb", {16'd0, cnt_nb}, 32'd51000);
    repeat (40) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, cnt_sat}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
